alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Execute-stage output stage directly downstream of the ALU. Captures the ALU
//  result/overflow with destination and PC into a 2-entry skid buffer, applies
//  the MIPS signed-overflow trap rule (no register writeback, raise exception),
//  and hands entries to the memory stage over a valid/ready handshake.
//  Holds the pipeline in TRAP until the exception unit acknowledges.
// PARAMETERS
//  DATA_W  32  width of ALU result and out_result
//  PC_W    32  width of in_pc / out_epc
//  CNT_W   16  width of saturating overflow-trap counter
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous active-low reset
//  in_valid     in   1       ALU output valid this cycle
//  in_ready     out  1       stage can accept (registered)
//  in_result    in   DATA_W  ALU result
//  in_overflow  in   1       ALU signed overflow flag
//  in_trap_en   in   1       op traps on overflow (add/sub/addi); 0 for addu/subu etc.
//  in_regwrite  in   1       op writes a register
//  in_dest      in   5       destination register
//  in_pc        in   PC_W    PC of the instruction
//  flush        in   1       synchronous discard of all buffered entries
//  out_valid    out  1       head entry presented
//  out_ready    in   1       downstream accepts head
//  out_result   out  DATA_W  head result
//  out_dest     out  5       head destination
//  out_regwrite out  1       head writeback enable (0 on trapped entry)
//  out_exc      out  1       head is an overflow-trap entry
//  out_epc      out  PC_W    head PC (exception PC when out_exc=1)
//  exc_ack      in   1       exception unit done; leave TRAP
//  ovf_count    out  CNT_W   number of trap entries delivered, saturating
// BEHAVIOUR
//  Reset (reset_n=0, async): count=0, state=RUN, in_ready=1, out_valid=0,
//   all data outputs 0, ovf_count=0. Reset mid-transfer drops all entries.
//  Accept: in_valid & in_ready at posedge writes entry to tail; exc bit =
//   in_overflow & in_trap_en; stored regwrite = in_regwrite & ~exc bit.
//  Drain: out_valid & out_ready at posedge pops head; skid entry moves to head.
//  Latency: accept in cycle N -> out_valid in N+1 when buffer was empty.
//  in_ready registered: 1 iff state==RUN and, after this edge, count<2
//   (combinational path in_ready<-out_ready forbidden). Simultaneous accept
//   and drain with count=1 keeps count=1, order preserved.
//  Full (count=2): in_ready=0; in_valid ignored. Empty: out_valid=0.
//  Outputs are driven from head entry; stable while out_valid & ~out_ready.
//  FSM RUN: normal. Draining an entry with exc=1 -> TRAP next cycle, clears
//   remaining (younger) entries, ovf_count += 1 unless all-ones (saturate).
//  FSM TRAP: in_ready=0, out_valid=0; exc_ack=1 -> RUN next cycle, in_ready=1
//   the cycle after. exc_ack in RUN ignored.
//  flush=1: buffer emptied at edge, no accept that cycle (in_valid ignored), no
//   drain counted; state unchanged (flush in TRAP still waits for exc_ack).
//   flush has priority over simultaneous accept/drain.
//  Trapped entry with exc=1 but in_trap_en=0 impossible: addu overflow passes
//   with out_exc=0, out_regwrite=in_regwrite.
// TESTING
//  1 Reset, push result=32'h0000_0005 dest=8 regwrite=1, out_ready=1 -> next
//    cycle out_valid=1 out_result=5 out_dest=8 out_regwrite=1 out_exc=0.
//  2 out_ready=0, push 3 entries back-to-back -> first two accepted, in_ready=0
//    after second; release out_ready -> entries exit in order, third then accepted.
//  3 add 32'h7FFF_FFFF+1 (overflow=1, trap_en=1, pc=32'h0040_0010) followed by
//    one more entry -> out_exc=1 out_regwrite=0 out_epc=32'h0040_0010; after
//    drain younger entry discarded, in_ready=0 until exc_ack, ovf_count=1.
//  4 addu overflow (overflow=1, trap_en=0) -> out_exc=0, out_regwrite=1,
//    ovf_count unchanged.
//  5 Buffer holds 2, assert flush with in_valid=1 -> count=0, out_valid=0 next
//    cycle, flushed-cycle input not captured.
//  6 Assert reset_n=0 asynchronously mid-drain in TRAP -> outputs zero
//    immediately, state RUN, in_ready=1 once reset_n released.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute-stage output buffer behind the ALU: 2-entry skid buffer, MIPS overflow
// trap handling, valid/ready hand-off to the memory stage, saturating trap counter.
module alu_result_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_overflow,
  input  logic              in_trap_en,
  input  logic              in_regwrite,
  input  logic [4:0]        in_dest,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_dest,
  output logic              out_regwrite,
  output logic              out_exc,
  output logic [PC_W-1:0]   out_epc,
  input  logic              exc_ack,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic [0:0] {ST_RUN, ST_TRAP} state_t;

  state_t              r_state;
  logic [1:0]          r_count;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_ovf_cnt;
  logic [DATA_W-1:0]   r_h_result, r_s_result;
  logic [4:0]          r_h_dest,   r_s_dest;
  logic                r_h_rw,     r_s_rw;
  logic                r_h_exc,    r_s_exc;
  logic [PC_W-1:0]     r_h_pc,     r_s_pc;

  state_t              w_state_nxt;
  logic [1:0]          w_count_nxt;
  logic                w_in_ready_nxt;
  logic                w_out_valid_nxt;
  logic [CNT_W-1:0]    w_ovf_cnt_nxt;
  logic [DATA_W-1:0]   w_h_result_nxt, w_s_result_nxt;
  logic [4:0]          w_h_dest_nxt,   w_s_dest_nxt;
  logic                w_h_rw_nxt,     w_s_rw_nxt;
  logic                w_h_exc_nxt,    w_s_exc_nxt;
  logic [PC_W-1:0]     w_h_pc_nxt,     w_s_pc_nxt;

  logic                w_exc;
  logic                w_rw;
  logic                w_acc;
  logic                w_pop;

  // Next-state, buffer movement and registered handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_ovf_cnt_nxt   = r_ovf_cnt;
    w_h_result_nxt  = r_h_result;
    w_h_dest_nxt    = r_h_dest;
    w_h_rw_nxt      = r_h_rw;
    w_h_exc_nxt     = r_h_exc;
    w_h_pc_nxt      = r_h_pc;
    w_s_result_nxt  = r_s_result;
    w_s_dest_nxt    = r_s_dest;
    w_s_rw_nxt      = r_s_rw;
    w_s_exc_nxt     = r_s_exc;
    w_s_pc_nxt      = r_s_pc;

    w_exc = in_overflow & in_trap_en;
    w_rw  = in_regwrite & ~w_exc;
    w_acc = in_valid & r_in_ready & ~flush;
    w_pop = r_out_valid & out_ready & ~flush;

    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_count_nxt = 2'd0;
        end else if (w_pop && r_h_exc) begin
          // Trap delivered: younger entries (including a same-cycle accept) are dropped
          w_state_nxt = ST_TRAP;
          w_count_nxt = 2'd0;
          if (r_ovf_cnt != {CNT_W{1'b1}}) w_ovf_cnt_nxt = r_ovf_cnt + CNT_W'(1);
        end else begin
          case ({w_pop, w_acc})
            2'b10: begin
              w_h_result_nxt = r_s_result;
              w_h_dest_nxt   = r_s_dest;
              w_h_rw_nxt     = r_s_rw;
              w_h_exc_nxt    = r_s_exc;
              w_h_pc_nxt     = r_s_pc;
              w_count_nxt    = r_count - 2'd1;
            end
            2'b01: begin
              if (r_count == 2'd0) begin
                w_h_result_nxt = in_result;
                w_h_dest_nxt   = in_dest;
                w_h_rw_nxt     = w_rw;
                w_h_exc_nxt    = w_exc;
                w_h_pc_nxt     = in_pc;
              end else begin
                w_s_result_nxt = in_result;
                w_s_dest_nxt   = in_dest;
                w_s_rw_nxt     = w_rw;
                w_s_exc_nxt    = w_exc;
                w_s_pc_nxt     = in_pc;
              end
              w_count_nxt = r_count + 2'd1;
            end
            2'b11: begin
              if (r_count == 2'd1) begin
                w_h_result_nxt = in_result;
                w_h_dest_nxt   = in_dest;
                w_h_rw_nxt     = w_rw;
                w_h_exc_nxt    = w_exc;
                w_h_pc_nxt     = in_pc;
              end else begin
                w_h_result_nxt = r_s_result;
                w_h_dest_nxt   = r_s_dest;
                w_h_rw_nxt     = r_s_rw;
                w_h_exc_nxt    = r_s_exc;
                w_h_pc_nxt     = r_s_pc;
                w_s_result_nxt = in_result;
                w_s_dest_nxt   = in_dest;
                w_s_rw_nxt     = w_rw;
                w_s_exc_nxt    = w_exc;
                w_s_pc_nxt     = in_pc;
              end
            end
            default: ;
          endcase
        end
      end
      ST_TRAP: begin
        if (flush) w_count_nxt = 2'd0;
        if (exc_ack) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase

    // in_ready returns one cycle after leaving TRAP
    w_in_ready_nxt  = (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && (w_count_nxt != 2'd2);
    w_out_valid_nxt = (w_state_nxt == ST_RUN) && (w_count_nxt != 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf_cnt   <= '0;
      r_h_result  <= '0;
      r_h_dest    <= '0;
      r_h_rw      <= 1'b0;
      r_h_exc     <= 1'b0;
      r_h_pc      <= '0;
      r_s_result  <= '0;
      r_s_dest    <= '0;
      r_s_rw      <= 1'b0;
      r_s_exc     <= 1'b0;
      r_s_pc      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_ovf_cnt   <= w_ovf_cnt_nxt;
      r_h_result  <= w_h_result_nxt;
      r_h_dest    <= w_h_dest_nxt;
      r_h_rw      <= w_h_rw_nxt;
      r_h_exc     <= w_h_exc_nxt;
      r_h_pc      <= w_h_pc_nxt;
      r_s_result  <= w_s_result_nxt;
      r_s_dest    <= w_s_dest_nxt;
      r_s_rw      <= w_s_rw_nxt;
      r_s_exc     <= w_s_exc_nxt;
      r_s_pc      <= w_s_pc_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_result   = r_h_result;
  assign out_dest     = r_h_dest;
  assign out_regwrite = r_h_rw;
  assign out_exc      = r_h_exc;
  assign out_epc      = r_h_pc;
  assign ovf_count    = r_ovf_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; small trap counter width so saturation is reachable.
module tb_alu_result_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 2;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_overflow;
  logic              in_trap_en;
  logic              in_regwrite;
  logic [4:0]        in_dest;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [4:0]        out_dest;
  logic              out_regwrite;
  logic              out_exc;
  logic [PC_W-1:0]   out_epc;
  logic              exc_ack;
  logic [CNT_W-1:0]  ovf_count;

  int total = 0;
  int bad   = 0;

  alu_result_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow), .in_trap_en(in_trap_en),
    .in_regwrite(in_regwrite), .in_dest(in_dest), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_regwrite(out_regwrite), .out_exc(out_exc),
    .out_epc(out_epc), .exc_ack(exc_ack), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs may change and outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic ovf,
                       input logic ten, input logic rw, input logic [4:0] d,
                       input logic [31:0] pc);
    in_valid = v; in_result = res; in_overflow = ovf; in_trap_en = ten;
    in_regwrite = rw; in_dest = d; in_pc = pc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; out_ready = 1'b0; flush = 1'b0; exc_ack = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(); step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== 32'h0 || out_epc !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0/0", out_result, out_epc); end
    total++; if (ovf_count !== 2'd0) begin bad++; $display("FAIL rst_ovf got=%0d exp=0", ovf_count); end
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0040_0000);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 32'h5 || out_dest !== 5'd8) begin bad++; $display("FAIL basic_data got=%h/%0d exp=5/8", out_result, out_dest); end
    total++; if (out_regwrite !== 1'b1 || out_exc !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b exp=10", out_regwrite, out_exc); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 5'd1, 32'h100);
    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 5'd2, 32'h104);
    step();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 5'd3, 32'h108);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    step();
    total++; if (out_result !== 32'hA || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%h/%b exp=a/1", out_result, out_valid); end
    out_ready = 1'b1;
    step();
    total++; if (out_result !== 32'hB || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=b/1", out_result, in_ready); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++; if (out_result !== 32'hC || out_dest !== 5'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_third got=%h/%0d/%b exp=c/3/1", out_result, out_dest, out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_trap();
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0040_0010);
    step();
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0040_0014);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++; if (out_exc !== 1'b1 || out_regwrite !== 1'b0) begin bad++; $display("FAIL trap_flags got=%b%b exp=10", out_exc, out_regwrite); end
    total++; if (out_epc !== 32'h0040_0010) begin bad++; $display("FAIL trap_epc got=%h exp=00400010", out_epc); end
    out_ready = 1'b1;
    step();
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 5'd4, 32'h200);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL trap_enter got=%b/%b exp=0/0", out_valid, in_ready); end
    total++; if (ovf_count !== 2'd1) begin bad++; $display("FAIL trap_cnt got=%0d exp=1", ovf_count); end
    step(); step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL trap_hold got=%b/%b exp=0/0", out_valid, in_ready); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL trap_ack_lag got=%b exp=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL trap_resume got=%b/%b exp=1/0", in_ready, out_valid); end
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL trap_ack_in_run got=%b exp=1", in_ready); end
  endtask

  task automatic test_addu();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd3, 32'h300);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++; if (out_exc !== 1'b0 || out_regwrite !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL addu_flags got=%b%b%b exp=011", out_exc, out_regwrite, out_valid); end
    step();
    total++; if (ovf_count !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL addu_cnt got=%0d/%b exp=1/1", ovf_count, in_ready); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 5'd5, 32'h400);
    step(); step();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 5'd6, 32'h408);
    flush = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_full got=%b/%b exp=0/1", out_valid, in_ready); end
    flush = 1'b0;
    step();
    drive(1'b1, 32'h23, 1'b0, 1'b0, 1'b1, 5'd7, 32'h40C);
    flush = 1'b1; out_ready = 1'b1;
    total++; if (out_result !== 32'h22 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_refill got=%h/%b exp=22/1", out_result, out_valid); end
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_one got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_capture got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt [3];
    exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 5'd12, 32'h500);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      total++; if (ovf_count !== exp_cnt[i]) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, ovf_count, exp_cnt[i]); end
      exc_ack = 1'b1; step(); exc_ack = 1'b0; step();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0040_0600);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL trap_flush got=%b/%b exp=0/0", in_ready, out_valid); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf_count !== 2'd0) begin bad++; $display("FAIL arst_ctl got=%b/%b/%0d exp=1/0/0", in_ready, out_valid, ovf_count); end
    total++; if (out_result !== 32'h0 || out_epc !== 32'h0 || out_exc !== 1'b0 || out_dest !== 5'd0) begin bad++; $display("FAIL arst_data got=%h/%h/%b/%0d exp=0/0/0/0", out_result, out_epc, out_exc, out_dest); end
    @(negedge clk); reset_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_release got=%b exp=1", in_ready); end
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 5'd14, 32'h700);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++; if (out_valid !== 1'b1 || out_result !== 32'h99) begin bad++; $display("FAIL arst_run got=%b/%h exp=1/99", out_valid, out_result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_trap();
    test_addu();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
